stream_demux: RTL and testbench

- Sequential counterpart to the mux examples. One valid/ready input stream is routed to one of N_OUT registered output channels.
- Routing is chosen per beat by a select input, the inverse of selecting one of several inputs.
- Each output channel holds a one-entry register slice, so every routed beat appears one cycle after acceptance.
- Sits between a single producer and several independent consumers in the homework pipeline exercises.

---
 rtl/stream_demux.sv | 82 ++++++++
 tb/tb_stream_demux.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready stream to one of N_OUT registered output channels.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   up_valid/up_ready     input handshake; up_ready is combinational and independent of up_valid
//   up_data, up_sel       input payload and destination channel index
//   dn_valid/dn_ready     per-channel output handshake, dn_valid registered
//   dn_data               per-channel registered payload, channel i at [i*WIDTH +: WIDTH]
//   sel_err               one-cycle pulse after a beat with up_sel >= N_OUT was accepted and dropped
// Macro STREAM_DEMUX_ROUND_ROBIN_EN: ignore up_sel and route by a rotating pointer instead.
module stream_demux #(
    parameter int N_OUT = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [WIDTH-1:0]       up_data,
    input  logic [SEL_W-1:0]       up_sel,
    output logic [N_OUT-1:0]       dn_valid,
    input  logic [N_OUT-1:0]       dn_ready,
    output logic [N_OUT*WIDTH-1:0] dn_data,
    output logic                   sel_err
);
    logic [SEL_W-1:0]       dst;
    logic                   dst_ok;
    logic                   accept;
    logic [N_OUT-1:0]       valid_q, valid_d;
    logic [N_OUT*WIDTH-1:0] data_q, data_d;
    logic                   err_q, err_d;
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic                   unused_sel;
    assign unused_sel = ^up_sel;
    // The pointer only ever holds 0..N_OUT-1, so the destination is always legal.
    assign dst    = ptr_q;
    assign dst_ok = 1'b1;
`else
    assign dst    = up_sel;
    assign dst_ok = int'(up_sel) < N_OUT;
`endif
    // Illegal destinations are always accepted so they can be dropped.
    assign up_ready = dst_ok ? (!valid_q[dst] || dn_ready[dst]) : 1'b1;
    assign accept   = up_valid && up_ready;
    always_comb begin
        valid_d = valid_q & ~dn_ready;
        data_d  = data_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (accept && dst_ok && int'(dst) == i) begin
                valid_d[i]                = 1'b1;
                data_d[i*WIDTH +: WIDTH] = up_data;
            end
        end
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
        err_d = 1'b0;
        ptr_d = !accept ? ptr_q : (int'(ptr_q) == N_OUT - 1) ? '0 : ptr_q + 1'b1;
`else
        err_d = accept && !dst_ok;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end
    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign sel_err  = err_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: scoreboard bench for stream_demux (N_OUT=4 main instance, N_OUT=3 for illegal select).
module tb_stream_demux;
    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [7:0]  up_data = '0;
    logic [1:0]  up_sel = '0;
    logic [3:0]  dn_valid;
    logic [3:0]  dn_ready = '1;
    logic [31:0] dn_data;
    logic        sel_err;

    logic        u3_valid = 1'b0;
    logic        u3_ready;
    logic [7:0]  u3_data = '0;
    logic [1:0]  u3_sel = '0;
    logic [2:0]  u3_dn_valid;
    logic [2:0]  u3_dn_ready = '1;
    logic [23:0] u3_dn_data;
    logic        u3_sel_err;

    exp_t sb[$];
    exp_t e;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    stream_demux #(.N_OUT(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
        .up_data(up_data), .up_sel(up_sel), .dn_valid(dn_valid), .dn_ready(dn_ready),
        .dn_data(dn_data), .sel_err(sel_err)
    );

    stream_demux #(.N_OUT(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .up_valid(u3_valid), .up_ready(u3_ready),
        .up_data(u3_data), .up_sel(u3_sel), .dn_valid(u3_dn_valid), .dn_ready(u3_dn_ready),
        .dn_data(u3_dn_data), .sel_err(u3_sel_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        sb.push_back('{ch: ch, d: d});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        up_valid = 1'b1;
        up_sel = 2'd0;
        up_data = 8'h55;
        dn_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (dn_valid !== 4'b0000) $display("FAIL reset_valid cyc%0d: got %b want 0000", i, dn_valid);
            else passed++;
            total++;
            if (sel_err !== 1'b0) $display("FAIL reset_sel_err cyc%0d: got %b want 0", i, sel_err);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 8'h55);
        cyc();
        up_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (dn_valid !== 4'b0001) $display("FAIL reset_first_beat_valid: got %b want 0001", dn_valid);
        else passed++;
        total++;
        if (dn_data[e.ch*8 +: 8] !== e.d) $display("FAIL reset_first_beat_data: got %h want %h", dn_data[e.ch*8 +: 8], e.d);
        else passed++;
    endtask

    task automatic test_single_route();
        up_sel = 2'd2;
        up_data = 8'hA5;
        up_valid = 1'b1;
        #1;
        total++;
        if (up_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", up_ready);
        else passed++;
        push(2, 8'hA5);
        cyc();
        up_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (dn_valid !== 4'b0100) $display("FAIL single_valid: got %b want 0100", dn_valid);
        else passed++;
        total++;
        if (dn_data[e.ch*8 +: 8] !== e.d) $display("FAIL single_data: got %h want %h", dn_data[e.ch*8 +: 8], e.d);
        else passed++;
        cyc();
        total++;
        if (dn_valid !== 4'b0000) $display("FAIL single_one_cycle: got %b want 0000", dn_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        dn_ready = 4'b1101;
        up_sel = 2'd1;
        up_data = 8'h11;
        up_valid = 1'b1;
        push(1, 8'h11);
        cyc();
        e = sb.pop_front();
        total++;
        if (dn_valid !== 4'b0010 || dn_data[e.ch*8 +: 8] !== e.d)
            $display("FAIL bp_first: got valid %b data %h want 0010 %h", dn_valid, dn_data[e.ch*8 +: 8], e.d);
        else passed++;
        up_data = 8'h22;
        #1;
        total++;
        if (up_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", up_ready);
        else passed++;
        cyc();
        total++;
        if (dn_valid[1] !== 1'b1 || dn_data[15:8] !== 8'h11)
            $display("FAIL bp_hold: got valid %b data %h want 1 11", dn_valid[1], dn_data[15:8]);
        else passed++;
        dn_ready = 4'b1111;
        #1;
        total++;
        if (up_ready !== 1'b1) $display("FAIL bp_ready_release: got %b want 1", up_ready);
        else passed++;
        push(1, 8'h22);
        cyc();
        up_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (dn_valid !== 4'b0010 || dn_data[e.ch*8 +: 8] !== e.d)
            $display("FAIL bp_second: got valid %b data %h want 0010 %h", dn_valid, dn_data[e.ch*8 +: 8], e.d);
        else passed++;
        cyc();
        total++;
        if (dn_valid !== 4'b0000) $display("FAIL bp_drain: got %b want 0000", dn_valid);
        else passed++;
    endtask

    task automatic test_independence();
        dn_ready = 4'b1000;
        up_sel = 2'd0;
        up_data = 8'h0C;
        up_valid = 1'b1;
        cyc();
        total++;
        if (dn_valid !== 4'b0001) $display("FAIL ind_ch0_full: got %b want 0001", dn_valid);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            up_sel = 2'd3;
            up_data = 8'h30 + 8'(k);
            #1;
            total++;
            if (up_ready !== 1'b1) $display("FAIL ind_ready beat%0d: got %b want 1", k, up_ready);
            else passed++;
            push(3, up_data);
            cyc();
            e = sb.pop_front();
            total++;
            if (dn_valid !== 4'b1001 || dn_data[e.ch*8 +: 8] !== e.d)
                $display("FAIL ind_ch3 beat%0d: got valid %b data %h want 1001 %h", k, dn_valid, dn_data[e.ch*8 +: 8], e.d);
            else passed++;
            total++;
            if (dn_data[7:0] !== 8'h0C) $display("FAIL ind_ch0_data beat%0d: got %h want 0c", k, dn_data[7:0]);
            else passed++;
        end
        up_valid = 1'b0;
        cyc();
        total++;
        if (dn_valid !== 4'b0001) $display("FAIL ind_ch3_drain: got %b want 0001", dn_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dn_valid !== 4'b0000 || dn_data !== 32'h0)
            $display("FAIL async_reset: got valid %b data %h want 0000 00000000", dn_valid, dn_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        dn_ready = 4'b1111;
        cyc();
    endtask

    task automatic test_invalid_sel();
        u3_dn_ready = 3'b111;
        u3_sel = 2'd3;
        u3_data = 8'hFF;
        u3_valid = 1'b1;
        #1;
        total++;
        if (u3_ready !== 1'b1) $display("FAIL inv_ready: got %b want 1", u3_ready);
        else passed++;
        cyc();
        u3_sel = 2'd2;
        u3_data = 8'h77;
        push(2, 8'h77);
        total++;
        if (u3_dn_valid !== 3'b000) $display("FAIL inv_no_valid: got %b want 000", u3_dn_valid);
        else passed++;
        total++;
        if (u3_sel_err !== 1'b1) $display("FAIL inv_err_pulse: got %b want 1", u3_sel_err);
        else passed++;
        cyc();
        u3_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (u3_sel_err !== 1'b0) $display("FAIL inv_err_one_cycle: got %b want 0", u3_sel_err);
        else passed++;
        total++;
        if (u3_dn_valid !== 3'b100 || u3_dn_data[e.ch*8 +: 8] !== e.d)
            $display("FAIL inv_last_ch: got valid %b data %h want 100 %h", u3_dn_valid, u3_dn_data[e.ch*8 +: 8], e.d);
        else passed++;
    endtask

    task automatic test_round_robin();
        dn_ready = 4'b1111;
        up_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            up_data = 8'(k + 1);
            up_sel = 2'd3;
            push(k % 4, up_data);
            cyc();
            e = sb.pop_front();
            total++;
            if (dn_valid !== (4'b0001 << e.ch) || dn_data[e.ch*8 +: 8] !== e.d)
                $display("FAIL rr_beat%0d: got valid %b data %h want ch%0d %h", k, dn_valid, dn_data[e.ch*8 +: 8], e.ch, e.d);
            else passed++;
        end
        up_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        up_data = 8'h01;
        up_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(k, up_data);
            cyc();
            e = sb.pop_front();
            total++;
            if (dn_valid !== (4'b0001 << e.ch) || dn_data[e.ch*8 +: 8] !== e.d)
                $display("FAIL rr_pre_reset%0d: got valid %b want ch%0d", k, dn_valid, e.ch);
            else passed++;
            up_data = up_data + 8'h01;
        end
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        up_data = 8'h03;
        push(0, 8'h03);
        cyc();
        up_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (dn_valid !== 4'b0001 || dn_data[7:0] !== e.d)
            $display("FAIL rr_restart: got valid %b data %h want 0001 %h", dn_valid, dn_data[7:0], e.d);
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
        test_reset();
        test_round_robin();
`else
        test_reset();
        test_single_route();
        test_backpressure();
        test_independence();
        test_async_reset();
        test_invalid_sel();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
